// File: rtl/user_io_bridge_tile.sv
// South-terminal bridge between fabric wires and user-project IO pins: per-channel sync,
// glitch filter, rising-edge pulse mode, optional output register and channel disable.
// Optional feature: define UIO_LOOPBACK_EN to add the Loopback port (UOUT fed back into the sync chains).
module user_io_bridge_tile #(
  parameter int NUM_CH      = 20,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4,
  parameter int OUT_REG     = 1
) (
  input  logic                UserCLK,
  input  logic                RST,
  input  logic [2*NUM_CH-1:0] ConfigBits,
`ifdef UIO_LOOPBACK_EN
  input  logic                Loopback,
`endif
  input  logic [NUM_CH-1:0]   UIN,
  output logic [NUM_CH-1:0]   FIN,
  input  logic [NUM_CH-1:0]   FOUT,
  output logic [NUM_CH-1:0]   UOUT
);

  localparam int              CW       = $clog2(FILTER_LEN);
  localparam logic [CW-1:0]   CNT_LAST = CW'(FILTER_LEN - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    MODE_DIRECT = 2'b00,
    MODE_FILTER = 2'b01,
    MODE_RISE   = 2'b10,
    MODE_OFF    = 2'b11
  } mode_e;

  logic [NUM_CH-1:0] samp_in;
  logic [NUM_CH-1:0] ch_off;
  logic [NUM_CH-1:0] uout_raw;

`ifdef UIO_LOOPBACK_EN
  // The sync flops break the UOUT -> FIN path, so looping back cannot form a combinational loop.
  assign samp_in = Loopback ? UOUT : UIN;
`else
  assign samp_in = UIN;
`endif

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : gen_ch
    mode_e                  mode;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   s;
    logic                   s_d_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   fin_q, fin_d;

    assign mode        = mode_e'(ConfigBits[2*gi +: 2]);
    assign sync_d      = {sync_q[SYNC_STAGES-2:0], samp_in[gi]};
    assign s           = sync_q[SYNC_STAGES-1];
    assign ch_off[gi]  = (mode == MODE_OFF);
    assign FIN[gi]     = fin_q;

    // Counter defaults to clear so any non-FILTER cycle (including OFF) restarts the debounce.
    always_comb begin
      fin_d = fin_q;
      cnt_d = '0;
      case (mode)
        MODE_DIRECT: fin_d = s;
        MODE_FILTER: begin
          if (s != fin_q) begin
            if (cnt_q == CNT_LAST) begin
              fin_d = s;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
        end
        MODE_RISE:   fin_d = s & ~s_d_q;
        default:     fin_d = 1'b0;
      endcase
    end

    always_ff @(posedge UserCLK) begin
      if (RST) begin
        sync_q <= '0;
        s_d_q  <= 1'b0;
        cnt_q  <= '0;
        fin_q  <= 1'b0;
      end else begin
        sync_q <= sync_d;
        s_d_q  <= s;
        cnt_q  <= cnt_d;
        fin_q  <= fin_d;
      end
    end
  end

  if (OUT_REG != 0) begin : gen_oreg
    logic [NUM_CH-1:0] uout_q;

    always_ff @(posedge UserCLK) begin
      if (RST) begin
        uout_q <= '0;
      end else begin
        uout_q <= FOUT;
      end
    end

    assign uout_raw = uout_q;
  end else begin : gen_ocomb
    assign uout_raw = FOUT & {NUM_CH{~RST}};
  end

  // A disabled channel never drives its pin, regardless of output path.
  assign UOUT = uout_raw & ~ch_off;

endmodule
